// File: rtl/param_shift_seq_reg.sv
// -----------------------------------------------------------------------------
// param_shift_seq_reg
//
// Multi-cycle load/shift register. A WIDTH-bit word is loaded in parallel and
// then shifted one position per clock for a programmed number of steps.
// Supported modes are logical, arithmetic, rotate and serial fill. A
// start/busy/done handshake frames each operation.
//
// Optional build feature:
//   PARAM_SHIFT_SEQ_REG_ZERO_FLAG_EN - adds the registered output 'zero'.
//   'zero' equals (q == 0) after every update of q and resets to 1.
// -----------------------------------------------------------------------------
module param_shift_seq_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
`ifdef PARAM_SHIFT_SEQ_REG_ZERO_FLAG_EN
    output logic             done,
    output logic             zero
`else
    output logic             done
`endif
);

    // Mode encodings
    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_SER = 2'b11;

    // Direction encodings
    localparam logic DIR_LEFT  = 1'b0;

    // Remaining-count value that marks the final shift
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
    localparam logic [AMT_W-1:0] CNT_ZERO = AMT_W'(0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // One single-position shift step.
    // Returns {bit_leaving, shifted_word}. Rotation by one step per clock makes
    // amounts of WIDTH or more wrap modulo WIDTH without any extra logic.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic             dir_i,
        input logic [1:0]       mode_i,
        input logic             sin_i
    );
        logic fill;
        logic out_bit;
        logic [WIDTH-1:0] res;
        begin
            case (mode_i)
                MODE_LOG: fill = 1'b0;
                // Arithmetic only differs from logical when shifting right
                MODE_ARI: fill = (dir_i == DIR_LEFT) ? 1'b0 : v[WIDTH-1];
                // The bit that leaves re-enters at the opposite end
                MODE_ROT: fill = (dir_i == DIR_LEFT) ? v[WIDTH-1] : v[0];
                MODE_SER: fill = sin_i;
                default:  fill = 1'b0;
            endcase
            if (dir_i == DIR_LEFT) begin
                out_bit = v[WIDTH-1];
                res     = {v[WIDTH-2:0], fill};
            end else begin
                out_bit = v[0];
                res     = {fill, v[WIDTH-1:1]};
            end
            shift_step = {out_bit, res};
        end
    endfunction

    // State and datapath registers
    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_serial_out;
    logic             r_busy;
    logic             r_done;
    logic [AMT_W-1:0] r_count;
    logic             r_dir;
    logic [1:0]       r_mode;

    // Next-state values
    state_t           w_state;
    logic [WIDTH-1:0] w_q;
    logic             w_serial_out;
    logic             w_busy;
    logic             w_done;
    logic [AMT_W-1:0] w_count;
    logic             w_dir;
    logic [1:0]       w_mode;
    logic [WIDTH:0]   w_step;

    // Next-state and datapath decode; every register holds unless a command acts
    always_comb begin
        w_state      = r_state;
        w_q          = r_q;
        w_serial_out = r_serial_out;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_count      = r_count;
        w_dir        = r_dir;
        w_mode       = r_mode;
        w_step       = shift_step(r_q, r_dir, r_mode, serial_in);

        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    // Load wins; a simultaneous start is dropped
                    w_q = d;
                end else if (start) begin
                    if (amount == CNT_ZERO) begin
                        // Nothing to shift: acknowledge immediately
                        w_done = 1'b1;
                    end else begin
                        // Capture the operation; shifting begins next edge
                        w_dir   = dir;
                        w_mode  = mode;
                        w_count = amount;
                        w_busy  = 1'b1;
                        w_state = ST_SHIFT;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (load) begin
                    // Abort: take the new word, no completion pulse
                    w_q     = d;
                    w_busy  = 1'b0;
                    w_count = CNT_ZERO;
                    w_state = ST_IDLE;
                end else begin
                    w_q          = w_step[WIDTH-1:0];
                    w_serial_out = w_step[WIDTH];
                    w_count      = r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_state = ST_IDLE;
                    end else begin
                        w_state = ST_SHIFT;
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover to a quiet idle
                w_busy  = 1'b0;
                w_count = CNT_ZERO;
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and datapath register update with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_q          <= '0;
            r_serial_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= '0;
            r_dir        <= 1'b0;
            r_mode       <= 2'b00;
        end else begin
            r_state      <= w_state;
            r_q          <= w_q;
            r_serial_out <= w_serial_out;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_count      <= w_count;
            r_dir        <= w_dir;
            r_mode       <= w_mode;
        end
    end

    assign q          = r_q;
    assign serial_out = r_serial_out;
    assign busy       = r_busy;
    assign done       = r_done;

`ifdef PARAM_SHIFT_SEQ_REG_ZERO_FLAG_EN
    logic r_zero;

    // Zero flag tracks the next value of q so it changes in the same cycle as q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero <= 1'b1;
        end else begin
            r_zero <= (w_q == '0);
        end
    end

    assign zero = r_zero;
`endif

endmodule

// File: tb/tb_param_shift_seq_reg.sv
// -----------------------------------------------------------------------------
// Self-checking bench for param_shift_seq_reg (WIDTH=8, AMT_W=4).
// A table of single-cycle vectors covers the basic flows; short hand-written
// sequences cover rotate wrap, abort and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_param_shift_seq_reg;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] d;
    logic       start;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] amount;
    logic       serial_in;
    logic [7:0] q;
    logic       serial_out;
    logic       busy;
    logic       done;
`ifdef PARAM_SHIFT_SEQ_REG_ZERO_FLAG_EN
    logic       zero;
`endif

    int checks = 0;
    int errors = 0;

    param_shift_seq_reg #(.WIDTH(8), .AMT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .d          (d),
        .start      (start),
        .dir        (dir),
        .mode       (mode),
        .amount     (amount),
        .serial_in  (serial_in),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
`ifdef PARAM_SHIFT_SEQ_REG_ZERO_FLAG_EN
        .done       (done),
        .zero       (zero)
`else
        .done       (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] dd;
        logic       st;
        logic       dr;
        logic [1:0] md;
        logic [3:0] amt;
        logic       sin;
        logic [7:0] eq;
        logic       eb;
        logic       ed;
        logic       eso;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] eq, input logic eb,
                           input logic ed, input logic eso);
        chk({nm, ".q"}, {24'h0, q}, {24'h0, eq});
        chk({nm, ".busy"}, {31'h0, busy}, {31'h0, eb});
        chk({nm, ".done"}, {31'h0, done}, {31'h0, ed});
        chk({nm, ".serial_out"}, {31'h0, serial_out}, {31'h0, eso});
`ifdef PARAM_SHIFT_SEQ_REG_ZERO_FLAG_EN
        chk({nm, ".zero"}, {31'h0, zero}, {31'h0, (eq == 8'h00)});
`endif
    endtask

    task automatic drive(input logic ld, input logic [7:0] dd, input logic st,
                         input logic dr, input logic [1:0] md, input logic [3:0] amt,
                         input logic sin);
        load      = ld;
        d         = dd;
        start     = st;
        dir       = dr;
        mode      = md;
        amount    = amt;
        serial_in = sin;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
    endtask

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ld  d      st    dir   mode   amt    sin   | q      busy  done  so
        // Arithmetic right by 3 on 0x81; dir/mode/amount/start toggled while busy
        vecs[0]  = '{1'b1, 8'h81, 1'b0, 1'b0, 2'b00, 4'd0,  1'b0, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 4'd3,  1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd15, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 4'd9,  1'b1, 8'hE0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b0, 8'hF0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
        // Load with start in the same cycle, then a zero-amount start
        vecs[6]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 2'b00, 4'd4,  1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 4'd0,  1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        // Serial fill of ones, right by 8, starting from zero
        vecs[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'b11, 4'd8,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b1, 8'hC0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b1, 8'hE0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b1, 8'hF0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b1, 8'hF8, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b1, 8'hFC, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0,  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};

        // Reset state
        reset = 1'b1;
        idle();
        #12;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ld, vecs[i].dd, vecs[i].st, vecs[i].dr, vecs[i].md,
                  vecs[i].amt, vecs[i].sin);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].eso);
        end

        // Rotate left by 12 on 0x96 wraps to rotate-by-4 = 0x69
        drive(1'b1, 8'h96, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 4'd12, 1'b0);
        tick();
        chk("rot.e0_busy", {31'h0, busy}, 32'd1);
        idle();
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("rot.e%0d_busy", i), {31'h0, busy}, (i < 12) ? 32'd1 : 32'd0);
            chk($sformatf("rot.e%0d_done", i), {31'h0, done}, (i == 12) ? 32'd1 : 32'd0);
        end
        chk_all("rot.end", 8'h69, 1'b0, 1'b1, 1'b1);
        tick();
        chk_all("rot.after", 8'h69, 1'b0, 1'b0, 1'b1);

        // Abort: logical left by 5 on 0x0F, start ignored at E2, load at E3
        drive(1'b1, 8'h0F, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 4'd5, 1'b0);
        tick();
        idle();
        tick();
        chk_all("abort.e1", 8'h1E, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 4'd2, 1'b0);
        tick();
        chk_all("abort.e2", 8'h3C, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
        tick();
        chk_all("abort.e3", 8'hA5, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("abort.post%0d", i), 8'hA5, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset between E2 and E3 of a logical left by 6 on 0xA5
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 4'd6, 1'b0);
        tick();
        idle();
        tick();
        chk_all("rst.e1", 8'h4A, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("rst.e2", 8'h94, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("rst.immediate", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rst.held", 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("rst.post%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
